// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide execution unit.
package alu_pkg;

    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned MD_OP_W = 3;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    // Divide by zero: every quotient bit is this value; remainder returns the dividend.
    localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/alu_mdu_if.sv
// Multiply/divide request handshake and HI/LO result bus.
interface alu_mdu_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();
    logic [MD_OP_W-1:0] md_op;
    logic               md_start;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;

    modport master (output md_op, md_start, input busy, done, HI, LO);
    modport slave  (input md_op, md_start, output busy, done, HI, LO);
endinterface

// File: rtl/md_iter.sv
// Iterative radix-2 shift-add multiply / restoring divide datapath on magnitudes,
// with sign correction applied to the final step's result.
module md_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);
    localparam int unsigned CW = SHW + 1;

    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   acc_q, sh_q, opb_q;
    logic               is_div_q, negq_q, negr_q, div0_q;

    logic               a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_abs_c, b_abs_c;
    logic [WIDTH:0]     mul_sum_c, div_shift_c, div_diff_c;
    logic [WIDTH-1:0]   acc_nxt_c, sh_nxt_c;
    logic [2*WIDTH-1:0] prod_c, prod_s_c;

    assign a_neg_c = op_signed & a[WIDTH-1];
    assign b_neg_c = op_signed & b[WIDTH-1];
    assign a_abs_c = a_neg_c ? ('0 - a) : a;
    assign b_abs_c = b_neg_c ? ('0 - b) : b;

    assign mul_sum_c   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift_c = {acc_q, sh_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, opb_q};

    // One iteration: acc is the product high half / partial remainder, sh the multiplier / quotient.
    always_comb begin
        acc_nxt_c = mul_sum_c[WIDTH:1];
        sh_nxt_c  = {mul_sum_c[0], sh_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff_c[WIDTH]) begin
                acc_nxt_c = div_diff_c[WIDTH-1:0];
                sh_nxt_c  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_c = div_shift_c[WIDTH-1:0];
                sh_nxt_c  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign prod_c   = {acc_nxt_c, sh_nxt_c};
    assign prod_s_c = negq_q ? ('0 - prod_c) : prod_c;
    assign last_c   = (cnt_q == CW'(1));

    always_comb begin
        hi_c = prod_s_c[2*WIDTH-1:WIDTH];
        lo_c = prod_s_c[WIDTH-1:0];
        if (is_div_q) begin
            hi_c = negr_q ? ('0 - acc_nxt_c) : acc_nxt_c;
            lo_c = negq_q ? ('0 - sh_nxt_c) : sh_nxt_c;
            if (div0_q) begin
                lo_c = {WIDTH{DIV0_Q_BIT}};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else if (load) begin
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            sh_q     <= a_abs_c;
            opb_q    <= b_abs_c;
            is_div_q <= op_div;
            negq_q   <= a_neg_c ^ b_neg_c;
            negr_q   <= a_neg_c;
            div0_q   <= op_div & (b == '0);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            acc_q <= acc_nxt_c;
            sh_q  <= sh_nxt_c;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execution unit: combinational ALU plus a start/busy multiply-divide unit owning HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [ALUOP_W-1:0] ALUOp,
    output logic [WIDTH-1:0]   C,
    output logic               Zero,
    output logic               Overflow,
    alu_mdu_if.slave           md
);
    logic [WIDTH-1:0] sum_c, diff_c;
    logic [SHW-1:0]   shamt_c;

    assign sum_c   = A + B;
    assign diff_c  = A - B;
    assign shamt_c = B[SHW-1:0];

    // ALU result and signed-overflow detection (ADD/SUB only).
    always_comb begin
        C        = '0;
        Overflow = 1'b0;
        case (ALUOp)
            ALU_ADD: begin
                C        = sum_c;
                Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                C        = diff_c;
                Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLL:  C = A << shamt_c;
            ALU_SRL:  C = A >> shamt_c;
            ALU_SRA:  C = WIDTH'($signed(A) >>> shamt_c);
            ALU_SLT:  C = WIDTH'($signed(A) < $signed(B));
            ALU_SLTU: C = WIDTH'(A < B);
            ALU_LUI:  C = B << (WIDTH / 2);
            default:  C = '0;
        endcase
    end

    assign Zero = (C == '0);

    md_state_t        state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             load_c, op_muldiv_c, op_div_c, op_signed_c;
    logic             last_c;
    logic [WIDTH-1:0] res_hi_c, res_lo_c;

    assign op_muldiv_c = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU)
                      || (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
    assign op_div_c    = (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
    assign op_signed_c = (md.md_op == MD_MULT) || (md.md_op == MD_DIV);

    md_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_c),
        .op_div    (op_div_c),
        .op_signed (op_signed_c),
        .a         (A),
        .b         (B),
        .last_c    (last_c),
        .hi_c      (res_hi_c),
        .lo_c      (res_lo_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Handshake: requests are only taken in IDLE, so a start while running is dropped.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_c  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md.md_start) begin
                    if (op_muldiv_c) begin
                        load_c  = 1'b1;
                        busy_d  = 1'b1;
                        state_d = MD_RUN;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_d = A;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            MD_RUN: begin
                if (last_c) begin
                    hi_d    = res_hi_c;
                    lo_d    = res_lo_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner cases plus random ALU and MDU traffic
// compared against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] a32, b32, c32;
    logic [3:0]  op32;
    logic        z32, v32;
    logic [15:0] a16, b16, c16;
    logic [3:0]  op16;
    logic        z16, v16;

    alu_mdu_if #(.WIDTH(32)) m32 ();
    alu_mdu_if #(.WIDTH(16)) m16 ();

    alu_mdu #(.WIDTH(32)) d32 (
        .clk(clk), .reset_n(reset_n), .A(a32), .B(b32), .ALUOp(op32),
        .C(c32), .Zero(z32), .Overflow(v32), .md(m32)
    );

    alu_mdu #(.WIDTH(16)) d16 (
        .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .ALUOp(op16),
        .C(c16), .Zero(z16), .Overflow(v16), .md(m16)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mhi = '0, mlo = '0;
    logic [2:0]  p_op;
    logic [31:0] p_a, p_b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ALU reference from plain integer arithmetic.
    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] c, output logic ovf);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic [63:0] sv;
        c   = '0;
        ovf = 1'b0;
        case (op)
            4'd0: begin c = a + b; s = sa + sb; sv = s; ovf = (sv[63:31] != {33{sv[31]}}); end
            4'd1: begin c = a - b; s = sa - sb; sv = s; ovf = (sv[63:31] != {33{sv[31]}}); end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = a ^ b;
            4'd5: c = ~(a | b);
            4'd6: c = a << b[4:0];
            4'd7: c = a >> b[4:0];
            4'd8: begin s = sa >>> b[4:0]; c = 32'(s); end
            4'd9: c = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: c = (a < b) ? 32'd1 : 32'd0;
            4'd11: c = {b[15:0], 16'h0000};
            default: c = '0;
        endcase
    endfunction

    // Architectural HI/LO update for one md_op.
    function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sp;
        logic [63:0] p;
        case (op)
            3'd0: begin sp = sa * sb; p = sp; mhi = p[63:32]; mlo = p[31:0]; end
            3'd1: begin p = 64'(a) * 64'(b); mhi = p[63:32]; mlo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    mlo = 32'hFFFF_FFFF; mhi = a;
                end else if (op == 3'd2) begin
                    mlo = 32'(sa / sb); mhi = 32'(sa % sb);
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
            3'd4: mhi = a;
            3'd5: mlo = a;
            default: ;
        endcase
    endfunction

    task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        p_op = op; p_a = a; p_b = b;
        m32.md_op = op; m32.md_start = 1'b1; a32 = a; b32 = b;
        tick;
        m32.md_start = 1'b0;
        a32 = $urandom; b32 = $urandom;
        chk("accept_busy", 64'(m32.busy), 64'd1);
    endtask

    task automatic md_finish(input string tag, input bit inject);
        int cyc = 0;
        while (m32.busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                chk({tag, "_hold"}, {m32.HI, m32.LO}, {mhi, mlo});
                if (inject) begin m32.md_op = MD_DIV; m32.md_start = 1'b1; end
            end
            tick;
            m32.md_start = 1'b0;
        end
        md_ref(p_op, p_a, p_b);
        chk({tag, "_latency"}, 64'(cyc), 64'd32);
        chk({tag, "_done"}, 64'(m32.done), 64'd1);
        chk({tag, "_hi"}, 64'(m32.HI), 64'(mhi));
        chk({tag, "_lo"}, 64'(m32.LO), 64'(mlo));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] ec;
        logic        ev;
        logic [3:0]  dops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd9, 4'd11};
        logic [31:0] dexp [8] = '{32'd48, 32'd16, 32'd0, 32'd48, 32'd48, 32'd0, 32'd0, 32'h0010_0000};

        reset_n = 1'b0;
        a32 = '0; b32 = '0; op32 = '0;
        a16 = '0; b16 = '0; op16 = '0;
        m32.md_op = '0; m32.md_start = 1'b0;
        m16.md_op = '0; m16.md_start = 1'b0;
        #2;
        chk("rst_hi", 64'(m32.HI), 64'd0);
        chk("rst_lo", 64'(m32.LO), 64'd0);
        chk("rst_busy", 64'(m32.busy), 64'd0);
        chk("rst_done", 64'(m32.done), 64'd0);
        tick; tick;
        reset_n = 1'b1;
        tick;

        // Directed ALU sweep with A=32, B=16.
        a32 = 32'd32; b32 = 32'd16;
        for (int i = 0; i < 8; i++) begin
            op32 = dops[i];
            #1;
            chk($sformatf("alu_dir_op%0d", dops[i]), 64'(c32), 64'(dexp[i]));
        end
        op32 = 4'd0; a32 = 32'h7FFF_FFFF; b32 = 32'd1;
        #1;
        chk("add_ovf_c", 64'(c32), 64'h8000_0000);
        chk("add_ovf_v", 64'(v32), 64'd1);
        op16 = 4'd0; a16 = 16'h7FFF; b16 = 16'd1;
        #1;
        chk("add16_ovf_v", 64'(v16), 64'd1);

        // Random ALU traffic.
        for (int i = 0; i < 60; i++) begin
            op32 = 4'($urandom_range(0, 15));
            a32  = $urandom;
            b32  = ($urandom_range(0, 3) == 0) ? a32 : $urandom;
            #1;
            alu_ref(op32, a32, b32, ec, ev);
            chk($sformatf("alu_rand_op%0d_c", op32), 64'(c32), 64'(ec));
            chk($sformatf("alu_rand_op%0d_z", op32), 64'(z32), 64'(ec == 32'd0));
            chk($sformatf("alu_rand_op%0d_v", op32), 64'(v32), 64'(ev));
        end
        tick;

        // Directed MDU cases, each followed by the end of the done pulse.
        md_issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);          md_finish("mult_m3x7", 1'b0);
        chk("mult_m3x7_hi_const", 64'(m32.HI), 64'hFFFF_FFFF);
        chk("mult_m3x7_lo_const", 64'(m32.LO), 64'hFFFF_FFEB);
        tick; chk("done_pulse", 64'(m32.done), 64'd0);
        md_issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); md_finish("multu_max", 1'b0);
        tick;
        md_issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);           md_finish("div_m7d2", 1'b0);
        tick;
        md_issue(MD_DIVU, 32'd7, 32'd2);                  md_finish("divu_7d2", 1'b0);
        tick;
        md_issue(MD_DIVU, 32'd5, 32'd0);                  md_finish("divu_by0", 1'b0);
        tick;
        md_issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);           md_finish("div_neg_by0", 1'b0);
        tick;
        md_issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   md_finish("div_min_m1", 1'b0);
        chk("div_min_m1_lo_const", 64'(m32.LO), 64'h8000_0000);
        tick;

        // Start during a run is dropped, not queued.
        md_issue(MD_MULT, 32'd1234, 32'hFFFF_0001);       md_finish("mult_ignore", 1'b1);
        tick;
        chk("ignore_not_queued", 64'(m32.busy), 64'd0);

        // Random back-to-back operations: each starts in the done cycle of the previous one.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = $urandom_range(1, 20);
            md_issue(3'($urandom_range(0, 3)), ra, rb);
            md_finish($sformatf("rand%0d_op%0d", i, p_op), 1'b0);
        end
        tick;

        // MTHI/MTLO write immediately; codes 6-7 do nothing.
        a32 = $urandom; m32.md_op = MD_MTHI; m32.md_start = 1'b1;
        tick;
        md_ref(MD_MTHI, a32, 32'd0);
        m32.md_op = 3'd6;
        chk("mthi_hi", 64'(m32.HI), 64'(mhi));
        chk("mthi_busy", 64'(m32.busy), 64'd0);
        chk("mthi_done", 64'(m32.done), 64'd0);
        tick;
        m32.md_start = 1'b0;
        chk("op6_hilo", {m32.HI, m32.LO}, {mhi, mlo});
        chk("op6_busy", 64'(m32.busy), 64'd0);

        // Reset in the middle of a run discards it.
        md_issue(MD_MULT, 32'd99, 32'd77);
        for (int i = 1; i < 10; i++) begin
            if (i == 5) begin m32.md_op = MD_DIV; m32.md_start = 1'b1; end
            tick;
            m32.md_start = 1'b0;
        end
        chk("pre_reset_busy", 64'(m32.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        mhi = '0; mlo = '0;
        chk("midrun_rst_hi", 64'(m32.HI), 64'd0);
        chk("midrun_rst_lo", 64'(m32.LO), 64'd0);
        chk("midrun_rst_busy", 64'(m32.busy), 64'd0);
        tick;
        reset_n = 1'b1;
        tick;
        a32 = 32'h1234; m32.md_op = MD_MTLO; m32.md_start = 1'b1;
        tick;
        m32.md_start = 1'b0;
        md_ref(MD_MTLO, 32'h1234, 32'd0);
        chk("mtlo_lo", 64'(m32.LO), 64'h1234);
        chk("mtlo_hi", 64'(m32.HI), 64'd0);
        chk("mtlo_busy", 64'(m32.busy), 64'd0);
        repeat (3) tick;
        chk("post_rst_idle", 64'(m32.busy), 64'd0);

        // WIDTH=16 instance: MULT 300 x 300.
        begin
            int cyc = 0;
            a16 = 16'd300; b16 = 16'd300; m16.md_op = MD_MULT; m16.md_start = 1'b1;
            tick;
            m16.md_start = 1'b0;
            a16 = 16'hABCD; b16 = 16'h1357;
            while (m16.busy === 1'b1 && cyc < 200) begin
                cyc++;
                tick;
            end
            chk("w16_latency", 64'(cyc), 64'd16);
            chk("w16_done", 64'(m16.done), 64'd1);
            chk("w16_hi", 64'(m16.HI), 64'h0001);
            chk("w16_lo", 64'(m16.LO), 64'h5F90);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execution unit for the datapath. It combines a combinational ALU with a sequential multiply/divide unit (MDU) that owns the HI/LO registers. The ALU result feeds the EX stage. The MDU runs iterative radix-2 multiply and divide under a start/busy handshake, so the control unit stalls dependent HI/LO reads while `busy` is high.

## Interface
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width, derived.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `A`  in  WIDTH  operand A (rs).
- `B`  in  WIDTH  operand B (rt/imm).
- `ALUOp`  in  4  ALU operation select.
- `C`  out  WIDTH  ALU result (combinational).
- `Zero`  out  1  C == 0.
- `Overflow`  out  1  signed overflow for ADD/SUB only; 0 otherwise.
- `md_op`  in  3  MDU operation select.
- `md_start`  in  1  request; sampled on the rising edge.
- `busy`  out  1  MDU iterating.
- `done`  out  1  one-cycle pulse when HI/LO take a new mult/div result.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- ALUOp codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA: shift A by B[SHW-1:0].
  - 9 SLT (signed), 10 SLTU: result is 1 or 0.
  - 11 LUI: B << WIDTH/2.
  - 12–15: C = 0.
- ADD/SUB wrap modulo 2^WIDTH. Overflow is set when the operand signs make the signed result invalid.
- md_op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are ignored.
- MDU FSM states are IDLE and RUN.
- IDLE with md_start=1:
  - MTHI/MTLO: write A into HI/LO at that edge. No busy, no done.
  - MULT*/DIV*: latch operands (absolute values for signed ops) and result signs, load counter = WIDTH, go to RUN.
- RUN:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring-division step per cycle.
  - Counter decrements each cycle. At zero: sign-correct the result, write HI/LO, go to IDLE.
- Multiply result: HI = upper half, LO = lower half of the 2·WIDTH product.
- Divide result: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
- Divide by zero (B=0): LO = all ones, HI = A. Same cycle count as a normal divide.
- Signed DIV of MIN / −1: LO = MIN, HI = 0.
- md_start while busy is ignored; it is not queued. HI/LO hold their old values for the whole run.

## Timing
- Reset (asynchronous, any time, including mid-run): HI=0, LO=0, busy=0, done=0, FSM=IDLE, counter=0. An in-flight operation is discarded.
- ALU outputs are combinational, with zero latency.
- Start of mult/div accepted at edge E0:
  - busy=1 from E0 until E_WIDTH.
  - At edge E_WIDTH: HI/LO update, busy=0, done=1 for exactly one cycle.
  - Latency is WIDTH cycles.
- A new md_start in the cycle where done=1 is accepted. Back-to-back operations therefore run with no idle cycle.
- MTHI/MTLO update HI/LO at the accepting edge. busy stays 0.

## Structure
- Package `alu_pkg`:
  - ALUOp and md_op localparam encodings.
  - MDU state enum.
  - Divide-by-zero result constants.
- Sub-module `md_iter` holds the iterative multiply/divide datapath: accumulator, shift register, counter, final sign correction.
- `alu_mdu` holds the ALU case logic, the handshake FSM and the HI/LO registers.

## Test plan
- ALU sweep, WIDTH=32, A=32, B=16:
  - ADD=48, SUB=16, AND=0, OR=48, XOR=48.
  - SRL=0 (shift 16), SLT=0, LUI=0x00100000.
  - ADD 0x7FFFFFFF+1 gives Overflow=1.
- MULT A=−3, B=7:
  - busy high exactly 32 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses once.
  - MULTU 0xFFFFFFFF² gives HI=0xFFFFFFFE, LO=1.
- DIV A=−7, B=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/2: LO=3, HI=1.
- DIVU 5/0: LO=0xFFFFFFFF, HI=5. DIV 0x80000000/−1: LO=0x80000000, HI=0.
- MULT started. At cycle 5 an md_start DIV is issued (ignored). At cycle 10 reset_n is pulsed low:
  - HI=LO=0 and busy=0 immediately.
  - After release, MTLO A=0x1234 sets LO=0x1234 the next edge with busy=0.
- WIDTH=16 instance: MULT 300×300 gives HI=0x0001, LO=0x5F90. busy is high 16 cycles.
